// File: rtl/mem_access_unit.sv
// Memory access stage: passes ALU results to writeback, issues data-memory
// requests for aligned loads/stores, waits for ack with a bounded timeout.
module mem_access_unit #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [63:0] alu_result,
  input  logic [63:0] store_data,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic [4:0]  rd,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [63:0] dmem_addr,
  output logic [63:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [63:0] dmem_rdata,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic {StIdle, StWaitAck} state_t;

  // Timeout fires at the end of the MAX_WAIT-th waiting cycle.
  localparam logic [7:0] LastCnt = 8'(MAX_WAIT - 1);

  localparam logic [1:0] ErrMisalign = 2'b01;
  localparam logic [1:0] ErrTimeout  = 2'b10;
  localparam logic [1:0] ErrIllegal  = 2'b11;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_req, w_req_nxt;
  logic        r_we, w_we_nxt;
  logic [63:0] r_addr, w_addr_nxt;
  logic [63:0] r_wdata, w_wdata_nxt;
  logic        r_is_load, w_is_load_nxt;
  logic [4:0]  r_op_rd, w_op_rd_nxt;
  logic        r_op_rw, w_op_rw_nxt;
  logic        r_wb_valid, w_wb_valid_nxt;
  logic        r_wb_rw, w_wb_rw_nxt;
  logic [4:0]  r_wb_rd, w_wb_rd_nxt;
  logic [63:0] r_wb_data, w_wb_data_nxt;
  logic        r_err, w_err_nxt;
  logic [1:0]  r_err_code, w_err_code_nxt;

  // Next-state and registered-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_req_nxt      = r_req;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_is_load_nxt  = r_is_load;
    w_op_rd_nxt    = r_op_rd;
    w_op_rw_nxt    = r_op_rw;
    w_wb_valid_nxt = 1'b0;
    w_wb_rw_nxt    = 1'b0;
    w_wb_rd_nxt    = r_wb_rd;
    w_wb_data_nxt  = r_wb_data;
    w_err_nxt      = 1'b0;
    w_err_code_nxt = 2'b00;
    unique case (r_state)
      StIdle: begin
        if (ex_valid) begin
          if (!mem_read && !mem_write) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_rw_nxt    = reg_write && (rd != 5'd31);
            w_wb_rd_nxt    = rd;
            w_wb_data_nxt  = alu_result;
          end else if (mem_read && mem_write) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_rd_nxt    = rd;
            w_wb_data_nxt  = alu_result;
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ErrIllegal;
          end else if (alu_result[2:0] != 3'b000) begin
            w_wb_valid_nxt = 1'b1;
            w_wb_rd_nxt    = rd;
            w_wb_data_nxt  = alu_result;
            w_err_nxt      = 1'b1;
            w_err_code_nxt = ErrMisalign;
          end else begin
            w_state_nxt   = StWaitAck;
            w_cnt_nxt     = 8'd0;
            w_req_nxt     = 1'b1;
            w_we_nxt      = mem_write;
            w_addr_nxt    = alu_result;
            w_wdata_nxt   = store_data;
            w_is_load_nxt = mem_read;
            w_op_rd_nxt   = rd;
            w_op_rw_nxt   = reg_write;
          end
        end
      end
      StWaitAck: begin
        // Ack takes priority over a timeout landing on the same edge.
        if (dmem_ack) begin
          w_state_nxt    = StIdle;
          w_req_nxt      = 1'b0;
          w_we_nxt       = 1'b0;
          w_wb_valid_nxt = 1'b1;
          w_wb_rd_nxt    = r_op_rd;
          w_wb_rw_nxt    = r_is_load && r_op_rw && (r_op_rd != 5'd31);
          w_wb_data_nxt  = r_is_load ? dmem_rdata : r_addr;
        end else if (r_cnt == LastCnt) begin
          w_state_nxt    = StIdle;
          w_req_nxt      = 1'b0;
          w_we_nxt       = 1'b0;
          w_wb_valid_nxt = 1'b1;
          w_wb_rd_nxt    = r_op_rd;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ErrTimeout;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_cnt      <= 8'd0;
      r_req      <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= 64'd0;
      r_wdata    <= 64'd0;
      r_is_load  <= 1'b0;
      r_op_rd    <= 5'd0;
      r_op_rw    <= 1'b0;
      r_wb_valid <= 1'b0;
      r_wb_rw    <= 1'b0;
      r_wb_rd    <= 5'd0;
      r_wb_data  <= 64'd0;
      r_err      <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_req      <= w_req_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_is_load  <= w_is_load_nxt;
      r_op_rd    <= w_op_rd_nxt;
      r_op_rw    <= w_op_rw_nxt;
      r_wb_valid <= w_wb_valid_nxt;
      r_wb_rw    <= w_wb_rw_nxt;
      r_wb_rd    <= w_wb_rd_nxt;
      r_wb_data  <= w_wb_data_nxt;
      r_err      <= w_err_nxt;
      r_err_code <= w_err_code_nxt;
    end
  end

  assign ex_ready     = (r_state == StIdle);
  assign dmem_req     = r_req;
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_wdata   = r_wdata;
  assign wb_valid     = r_wb_valid;
  assign wb_reg_write = r_wb_rw;
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign err          = r_err;
  assign err_code     = r_err_code;

endmodule
